// File: rtl/ascon_wdma_sched_pkg.sv
`default_nettype none
// ============================================================================
// ascon_wdma_sched_pkg : shared types and constants for the write-DMA scheduler
// Revision : 1.0
// ============================================================================
package ascon_wdma_sched_pkg;

    typedef enum logic [1:0] {
        SCHED_IDLE  = 2'd0,
        SCHED_ISSUE = 2'd1,
        SCHED_WAIT  = 2'd2,
        SCHED_DONE  = 2'd3
    } wdma_sched_state_e;

    localparam int unsigned WDMA_SCHED_TIMEOUT_DEF = 4096;
    localparam int unsigned WDMA_ADDR_W            = 32;
    localparam int unsigned WDMA_LEN_W             = 32;

    function automatic int unsigned sched_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ascon_wdma_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : combinational round-robin pick of the first request at or
//              after the pointer, wrapping; one-hot grant plus index.
// Revision : 1.0
// ============================================================================
module rr_arbiter #(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    always_comb begin : p_pick
        int unsigned cand;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        for (int unsigned off = 0; off < N; off++) begin
            cand = (32'(ptr_i) + off) % N;
            if (!valid_o && req_i[IDX_W'(cand)]) begin
                valid_o              = 1'b1;
                gnt_o[IDX_W'(cand)]  = 1'b1;
                idx_o                = IDX_W'(cand);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ascon_wdma_sched.sv
`default_nettype none
// ============================================================================
// ascon_wdma_sched : round-robin command scheduler sharing one write DMA
//                    between NUM_REQ requesters, with a hang watchdog.
// Revision : 1.0
// ============================================================================
module ascon_wdma_sched
    import ascon_wdma_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned TIMEOUT_CYC = WDMA_SCHED_TIMEOUT_DEF,
    parameter int unsigned ID_W        = sched_idx_w(NUM_REQ)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    enable_i,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    input  logic [NUM_REQ*32-1:0]   req_addr_i,
    input  logic [NUM_REQ*32-1:0]   req_len_i,
    output logic [NUM_REQ-1:0]      done_o,
    output logic                    grant_valid_o,
    output logic [ID_W-1:0]         grant_id_o,
    output logic                    awvalid_o,
    input  logic                    awready_i,
    output logic [31:0]             awaddr_o,
    output logic [31:0]             awlen_o,
    output logic                    busy_o,
    output logic                    err_o,
    input  logic                    err_clr_i
);

    localparam bit          WD_EN  = (TIMEOUT_CYC != 0);
    localparam int unsigned WD_W   = WD_EN ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC);

    wdma_sched_state_e    state_q, state_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          len_q, len_d;
    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
    logic [WD_W-1:0]      wd_q, wd_d;
    logic                 err_q, err_d;

    logic [31:0]          addr_arr [NUM_REQ];
    logic [31:0]          len_arr  [NUM_REQ];
    logic [NUM_REQ-1:0]   arb_gnt;
    logic [ID_W-1:0]      arb_idx;
    logic                 arb_valid;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g] = req_addr_i[g*32 +: 32];
        assign len_arr[g]  = req_len_i[g*32 +: 32];
    end

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_arb (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= SCHED_IDLE;
            id_q        <= '0;
            ptr_q       <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            req_ready_q <= '0;
            wd_q        <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            ptr_q       <= ptr_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            req_ready_q <= req_ready_d;
            wd_q        <= wd_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        ptr_d       = ptr_q;
        addr_d      = addr_q;
        len_d       = len_q;
        req_ready_d = '0;
        wd_d        = wd_q;
        err_d       = err_q & ~err_clr_i;
        unique case (state_q)
            SCHED_IDLE: begin
                // The decision is registered: the ready pulse cycle commits the move.
                if (|req_ready_q) begin
                    state_d = (len_q == 32'd0) ? SCHED_DONE : SCHED_ISSUE;
                end else if (enable_i && arb_valid) begin
                    id_d        = arb_idx;
                    addr_d      = addr_arr[arb_idx];
                    len_d       = len_arr[arb_idx];
                    req_ready_d = arb_gnt;
                end
            end
            SCHED_ISSUE: begin
                if (awready_i) begin
                    state_d = SCHED_WAIT;
                end
            end
            SCHED_WAIT: begin
                if (WD_EN) begin
                    wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + WD_W'(1);
                    if (wd_d == WD_MAX) begin
                        err_d = 1'b1;
                    end
                end
                if (awready_i) begin
                    state_d = SCHED_DONE;
                end
            end
            SCHED_DONE: begin
                ptr_d   = (32'(id_q) == NUM_REQ - 1) ? '0 : id_q + ID_W'(1);
                wd_d    = '0;
                state_d = SCHED_IDLE;
            end
            default: begin
                state_d = SCHED_IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready_o   = req_ready_q;
        grant_id_o    = id_q;
        err_o         = err_q;
        busy_o        = (state_q != SCHED_IDLE);
        awvalid_o     = (state_q == SCHED_ISSUE);
        awaddr_o      = (state_q == SCHED_ISSUE) ? addr_q : '0;
        awlen_o       = (state_q == SCHED_ISSUE) ? len_q  : '0;
        grant_valid_o = (state_q == SCHED_ISSUE) || (state_q == SCHED_WAIT) ||
                        ((state_q == SCHED_DONE) && (len_q == 32'd0));
        done_o        = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            done_o[i] = (state_q == SCHED_DONE) && (32'(id_q) == i);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ascon_wdma_sched.sv
`default_nettype none
// ============================================================================
// tb_ascon_wdma_sched : scoreboard bench with requester and stub-DMA models
// Revision : 1.0
// ============================================================================
module tb_ascon_wdma_sched;

    localparam int NR = 2;
    localparam int TO = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR*32-1:0] req_addr;
    logic [NR*32-1:0] req_len;
    logic [NR-1:0]    done;
    logic             grant_valid;
    logic [0:0]       grant_id;
    logic             awvalid;
    logic             awready;
    logic [31:0]      awaddr;
    logic [31:0]      awlen;
    logic             busy;
    logic             err;
    logic             err_clr;

    always #5 clk = ~clk;

    ascon_wdma_sched #(
        .NUM_REQ     (NR),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .enable_i      (enable),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_addr_i    (req_addr),
        .req_len_i     (req_len),
        .done_o        (done),
        .grant_valid_o (grant_valid),
        .grant_id_o    (grant_id),
        .awvalid_o     (awvalid),
        .awready_i     (awready),
        .awaddr_o      (awaddr),
        .awlen_o       (awlen),
        .busy_o        (busy),
        .err_o         (err),
        .err_clr_i     (err_clr)
    );

    typedef struct {
        int          id;
        logic [31:0] addr;
        logic [31:0] len;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    bit          active;
    int          n_checks, n_fail;
    int          cyc;
    int          total [NR];
    int          issued[NR];
    logic [31:0] base  [NR];
    logic [31:0] lenv  [NR];
    int          hold_cfg, hold;
    bit          accept_pend, in_wait, wd_chk;
    int          wait_cnt, raise_cyc, ready_cyc;
    int          n_ready, n_done, n_aw;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NR; i++) begin
            req_valid[i]         = (issued[i] < total[i]);
            req_addr[i*32 +: 32] = base[i] + 32'(issued[i]) * 32'h100;
            req_len[i*32 +: 32]  = lenv[i];
        end
    endtask

    // Requester k-th command of id: address base + k*0x100, current length.
    task automatic add_cmd(input int id);
        exp_t e;
        e.id   = id;
        e.addr = base[id] + 32'(total[id]) * 32'h100;
        e.len  = lenv[id];
        exp_q.push_back(e);
        total[id]++;
        drive_reqs();
    endtask

    // One cycle: observe at the falling edge, then update DMA/requester models.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            active      = 1'b0;
            in_wait     = 1'b0;
            accept_pend = 1'b0;
            awready     = 1'b1;
            drive_reqs();
            return;
        end
        if (accept_pend) begin
            accept_pend = 1'b0;
            in_wait     = 1'b1;
            wait_cnt    = 1;
            awready     = 1'b0;
            hold        = hold_cfg;
        end else if (in_wait) begin
            wait_cnt++;
            if (!awready) begin
                if (hold > 0) hold--;
                if (hold == 0) begin
                    awready   = 1'b1;
                    raise_cyc = cyc;
                end
            end
        end
        // err rises once 32 full WAIT cycles have elapsed.
        if (in_wait && wd_chk) begin
            if (wait_cnt == TO)     check_eq("err_pre_timeout", 64'(err), 64'd0);
            if (wait_cnt == TO + 1) check_eq("err_at_timeout", 64'(err), 64'd1);
        end
        if (req_ready != '0) begin
            n_ready++;
            ready_cyc = cyc;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_ready", 64'(req_ready), 64'd0);
            end else begin
                cur    = exp_q.pop_front();
                active = 1'b1;
                check_eq("ready_onehot", 64'(req_ready), 64'd1 << cur.id);
                check_eq("gid_at_ready", 64'(grant_id), 64'(cur.id));
            end
            for (int i = 0; i < NR; i++) if (req_ready[i]) issued[i]++;
        end else if (active) begin
            check_eq("gid_hold", 64'(grant_id), 64'(cur.id));
        end
        if (awvalid && active) check_eq("gv_issue", 64'(grant_valid), 64'd1);
        if (awvalid && awready) begin
            n_aw++;
            accept_pend = 1'b1;
            if (!active) begin
                check_eq("aw_unexpected", 64'(awvalid), 64'd0);
            end else begin
                check_eq("awaddr", 64'(awaddr), 64'(cur.addr));
                check_eq("awlen", 64'(awlen), 64'(cur.len));
                check_eq("aw_nonzero_len", 64'(cur.len != 0), 64'd1);
            end
        end
        if (done != '0) begin
            n_done++;
            if (!active) begin
                check_eq("done_unexpected", 64'(done), 64'd0);
            end else begin
                check_eq("done_onehot", 64'(done), 64'd1 << cur.id);
                if (cur.len == 0) begin
                    check_eq("done_zero_len_lat", 64'(cyc), 64'(ready_cyc + 1));
                    check_eq("gv_zero_len", 64'(grant_valid), 64'd1);
                end else begin
                    check_eq("done_lat", 64'(cyc), 64'(raise_cyc + 1));
                end
            end
            active  = 1'b0;
            in_wait = 1'b0;
        end
        drive_reqs();
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || active) && n < max_cyc) begin
            tick();
            n++;
        end
        check_eq(tag, 64'(exp_q.size()) + 64'(active), 64'd0);
        tick();
    endtask

    initial begin : main
        int r0, aw0, d0, guard;
        n_checks = 0; n_fail = 0; cyc = 0;
        active = 1'b0; accept_pend = 1'b0; in_wait = 1'b0; wd_chk = 1'b0;
        wait_cnt = 0; raise_cyc = 0; ready_cyc = 0; hold = 0;
        n_ready = 0; n_done = 0; n_aw = 0;
        for (int i = 0; i < NR; i++) begin
            total[i] = 0; issued[i] = 0;
        end
        base[0] = 32'h1000_0003; base[1] = 32'h2000_0000;
        lenv[0] = 32'd13;        lenv[1] = 32'd64;
        hold_cfg = 5;
        enable = 1'b1; err_clr = 1'b0; awready = 1'b1;
        rst_n = 1'b1;
        drive_reqs();
        #1 rst_n = 1'b0;
        repeat (3) tick();
        check_eq("rst_ctrl", 64'({req_ready, done, grant_valid, grant_id, awvalid, busy, err}), 64'd0);
        check_eq("rst_awaddr_len", {awaddr, awlen}, 64'd0);
        rst_n = 1'b1;
        tick();

        // Single command, DMA busy for 5 responses
        lenv[0] = 32'd13; hold_cfg = 5;
        add_cmd(0);
        wait_idle("t1_complete", 100);
        check_eq("t1_done_count", 64'(n_done), 64'd1);
        check_eq("t1_aw_count", 64'(n_aw), 64'd1);
        check_eq("t1_no_err", 64'(err), 64'd0);

        // Zero-length command from req1: no DMA command
        lenv[1] = 32'd0;
        aw0 = n_aw;
        add_cmd(1);
        wait_idle("t3_complete", 100);
        check_eq("t3_no_aw", 64'(n_aw), 64'(aw0));
        check_eq("t3_done_count", 64'(n_done), 64'd2);

        // Both requesters loaded with three commands each: strict alternation
        lenv[1] = 32'd64; hold_cfg = 3;
        repeat (3) begin
            add_cmd(0);
            add_cmd(1);
        end
        wait_idle("t2_complete", 500);
        check_eq("t2_done_count", 64'(n_done), 64'd8);

        // Disabled scheduler holds off, grant one cycle after enable
        enable = 1'b0; hold_cfg = 2; lenv[0] = 32'd8;
        r0 = n_ready;
        add_cmd(0);
        repeat (10) tick();
        check_eq("t5_no_grant", 64'(n_ready), 64'(r0));
        check_eq("t5_not_busy", 64'(busy), 64'd0);
        enable = 1'b1;
        tick();
        check_eq("t5_ready_next", 64'(n_ready), 64'(r0 + 1));
        wait_idle("t5_complete", 100);

        // Watchdog: DMA stalls 40 cycles against a 32-cycle timeout
        hold_cfg = 40; lenv[0] = 32'd32; wd_chk = 1'b1;
        add_cmd(0);
        wait_idle("t4_complete", 200);
        wd_chk = 1'b0;
        check_eq("t4_err_sticky", 64'(err), 64'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_eq("t4_err_cleared", 64'(err), 64'd0);

        // Reset asserted while waiting on the DMA
        hold_cfg = 20; lenv[0] = 32'd16;
        add_cmd(0);
        guard = 0;
        while (!(in_wait && wait_cnt >= 3) && guard < 50) begin
            tick();
            guard++;
        end
        check_eq("t6_in_wait", 64'(in_wait), 64'd1);
        d0 = n_done;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6_rst_ctrl", 64'({req_ready, done, grant_valid, grant_id, awvalid, busy, err}), 64'd0);
        check_eq("t6_rst_awaddr_len", {awaddr, awlen}, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("t6_no_done", 64'(n_done), 64'(d0));
        hold_cfg = 2;
        add_cmd(0);
        add_cmd(1);
        wait_idle("t6_regrant", 200);
        check_eq("t6_done_count", 64'(n_done), 64'(d0 + 2));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : global_guard
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got %0t expected < 500000", $time);
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
